// File: rtl/control_unit_pkg.sv
// Shared definitions for the 8-bit CPU: opcodes (also used by the ALU),
// sequencer state encoding and bus mux select codes.
package cpu_pkg;

    localparam int unsigned WORD_SIZE = 8;
    localparam int unsigned OP_SIZE   = 4;
    localparam int unsigned SEL1_SIZE = 3;
    localparam int unsigned SEL2_SIZE = 2;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_NOT = 4'd4,
        OP_RD  = 4'd5,
        OP_WR  = 4'd6,
        OP_BR  = 4'd7,
        OP_BRZ = 4'd8
    } opcode_t;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_FET1 = 4'd1,
        S_FET2 = 4'd2,
        S_DEC  = 4'd3,
        S_EX1  = 4'd4,
        S_RD1  = 4'd5,
        S_RD2  = 4'd6,
        S_WR1  = 4'd7,
        S_WR2  = 4'd8,
        S_BR1  = 4'd9,
        S_BR2  = 4'd10,
        S_HALT = 4'd11
    } state_t;

    localparam logic [SEL1_SIZE-1:0] SEL1_R0 = 3'd0;
    localparam logic [SEL1_SIZE-1:0] SEL1_R1 = 3'd1;
    localparam logic [SEL1_SIZE-1:0] SEL1_R2 = 3'd2;
    localparam logic [SEL1_SIZE-1:0] SEL1_R3 = 3'd3;
    localparam logic [SEL1_SIZE-1:0] SEL1_PC = 3'd4;

    localparam logic [SEL2_SIZE-1:0] SEL2_ALU  = 2'd0;
    localparam logic [SEL2_SIZE-1:0] SEL2_BUS1 = 2'd1;
    localparam logic [SEL2_SIZE-1:0] SEL2_MEM  = 2'd2;

endpackage

// File: rtl/control_unit_if.sv
// Control bundle between the sequencer (master) and the CPU datapath (slave).
interface control_unit_if #(
    parameter int unsigned word_size = 8,
    parameter int unsigned op_size   = 4,
    parameter int unsigned sel1_size = 3,
    parameter int unsigned sel2_size = 2
);

    logic [word_size-1:0] instruction;
    logic                 zero;
    logic                 load_R0;
    logic                 load_R1;
    logic                 load_R2;
    logic                 load_R3;
    logic                 load_PC;
    logic                 inc_PC;
    logic                 load_IR;
    logic                 load_Add_R;
    logic                 load_Reg_Y;
    logic                 load_Reg_Z;
    logic [sel1_size-1:0] sel_bus_1_mux;
    logic [sel2_size-1:0] sel_bus_2_mux;
    logic                 write;
    logic [op_size-1:0]   alu_sel;
    logic                 halted;

    modport master (
        input  instruction, zero,
        output load_R0, load_R1, load_R2, load_R3, load_PC, inc_PC, load_IR,
               load_Add_R, load_Reg_Y, load_Reg_Z, sel_bus_1_mux, sel_bus_2_mux,
               write, alu_sel, halted
    );

    modport slave (
        output instruction, zero,
        input  load_R0, load_R1, load_R2, load_R3, load_PC, inc_PC, load_IR,
               load_Add_R, load_Reg_Y, load_Reg_Z, sel_bus_1_mux, sel_bus_2_mux,
               write, alu_sel, halted
    );

endinterface

// File: rtl/control_unit.sv
// Instruction sequencer for the 8-bit CPU: fetch, decode and execute control.
// Only the state is registered; every strobe decodes from state, IR and zero.
module control_unit
    import cpu_pkg::*;
#(
    parameter int unsigned word_size = 8,
    parameter int unsigned op_size   = 4,
    parameter int unsigned sel1_size = 3,
    parameter int unsigned sel2_size = 2
) (
    input  logic           clk,
    input  logic           rst,
    control_unit_if.master bus
);

    state_t state, next_state;

    logic [op_size-1:0]   opcode;
    logic [1:0]           src;
    logic [1:0]           dest;
    logic [3:0]           load_r;
    logic                 load_pc;
    logic                 inc_pc;
    logic                 load_ir;
    logic                 load_add_r;
    logic                 load_reg_y;
    logic                 load_reg_z;
    logic [sel1_size-1:0] sel1;
    logic [sel2_size-1:0] sel2;
    logic                 write;
    logic [op_size-1:0]   alu_sel;
    logic                 halted;

    assign opcode = bus.instruction[word_size-1 -: op_size];
    assign src    = bus.instruction[3:2];
    assign dest   = bus.instruction[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        load_r     = '0;
        load_pc    = 1'b0;
        inc_pc     = 1'b0;
        load_ir    = 1'b0;
        load_add_r = 1'b0;
        load_reg_y = 1'b0;
        load_reg_z = 1'b0;
        sel1       = '0;
        sel2       = '0;
        write      = 1'b0;
        alu_sel    = OP_NOP;
        halted     = 1'b0;

        unique case (state)
            S_IDLE: next_state = S_FET1;
            S_FET1: begin
                sel1       = SEL1_PC;
                sel2       = SEL2_BUS1;
                load_add_r = 1'b1;
                inc_pc     = 1'b1;
                next_state = S_FET2;
            end
            S_FET2: begin
                sel2       = SEL2_MEM;
                load_ir    = 1'b1;
                next_state = S_DEC;
            end
            S_DEC: begin
                case (opcode)
                    OP_NOP: next_state = S_FET1;
                    OP_ADD, OP_SUB, OP_AND: begin
                        sel1       = sel1_size'(src);
                        sel2       = SEL2_BUS1;
                        load_reg_y = 1'b1;
                        next_state = S_EX1;
                    end
                    OP_NOT: begin
                        sel1         = sel1_size'(src);
                        alu_sel      = OP_NOT;
                        sel2         = SEL2_ALU;
                        load_r[dest] = 1'b1;
                        load_reg_z   = 1'b1;
                        next_state   = S_FET1;
                    end
                    OP_RD, OP_WR, OP_BR, OP_BRZ: begin
                        // Untaken BRZ only steps PC past the address byte.
                        if (opcode == OP_BRZ && !bus.zero) begin
                            inc_pc     = 1'b1;
                            next_state = S_FET1;
                        end else begin
                            sel1       = SEL1_PC;
                            sel2       = SEL2_BUS1;
                            load_add_r = 1'b1;
                            if (opcode == OP_RD)      next_state = S_RD1;
                            else if (opcode == OP_WR) next_state = S_WR1;
                            else                      next_state = S_BR1;
                        end
                    end
                    default: next_state = S_HALT;
                endcase
            end
            S_EX1: begin
                sel1         = sel1_size'(dest);
                alu_sel      = opcode;
                sel2         = SEL2_ALU;
                load_r[dest] = 1'b1;
                load_reg_z   = 1'b1;
                next_state   = S_FET1;
            end
            S_RD1: begin
                sel2       = SEL2_MEM;
                load_add_r = 1'b1;
                inc_pc     = 1'b1;
                next_state = S_RD2;
            end
            S_RD2: begin
                sel2         = SEL2_MEM;
                load_r[dest] = 1'b1;
                next_state   = S_FET1;
            end
            S_WR1: begin
                sel2       = SEL2_MEM;
                load_add_r = 1'b1;
                inc_pc     = 1'b1;
                next_state = S_WR2;
            end
            S_WR2: begin
                sel1       = sel1_size'(src);
                write      = 1'b1;
                next_state = S_FET1;
            end
            S_BR1: begin
                sel2       = SEL2_MEM;
                load_add_r = 1'b1;
                next_state = S_BR2;
            end
            S_BR2: begin
                sel2       = SEL2_MEM;
                load_pc    = 1'b1;
                next_state = S_FET1;
            end
            S_HALT: begin
                halted     = 1'b1;
                next_state = S_HALT;
            end
            default: next_state = S_IDLE;
        endcase
    end

    assign bus.load_R0       = load_r[0];
    assign bus.load_R1       = load_r[1];
    assign bus.load_R2       = load_r[2];
    assign bus.load_R3       = load_r[3];
    assign bus.load_PC       = load_pc;
    assign bus.inc_PC        = inc_pc;
    assign bus.load_IR       = load_ir;
    assign bus.load_Add_R    = load_add_r;
    assign bus.load_Reg_Y    = load_reg_y;
    assign bus.load_Reg_Z    = load_reg_z;
    assign bus.sel_bus_1_mux = sel1;
    assign bus.sel_bus_2_mux = sel2;
    assign bus.write         = write;
    assign bus.alu_sel       = alu_sel;
    assign bus.halted        = halted;

endmodule

// File: tb/tb_control_unit.sv
// Randomized bench for control_unit: each instruction is expanded into its
// expected per-cycle control words and compared cycle by cycle.
module tb_control_unit;

    typedef struct packed {
        logic [3:0] load_r;
        logic       load_pc;
        logic       inc_pc;
        logic       load_ir;
        logic       load_add_r;
        logic       load_reg_y;
        logic       load_reg_z;
        logic [2:0] sel1;
        logic [1:0] sel2;
        logic       write;
        logic [3:0] alu_sel;
        logic       halted;
    } ctl_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int unsigned checks = 0;
    int unsigned errors = 0;

    ctl_t exp_q[$];

    control_unit_if #(.word_size(8), .op_size(4), .sel1_size(3), .sel2_size(2)) cu_bus ();

    control_unit #(.word_size(8), .op_size(4), .sel1_size(3), .sel2_size(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (cu_bus.master)
    );

    always #5 clk = ~clk;

    function automatic ctl_t observe();
        ctl_t c;
        c.load_r     = {cu_bus.load_R3, cu_bus.load_R2, cu_bus.load_R1, cu_bus.load_R0};
        c.load_pc    = cu_bus.load_PC;
        c.inc_pc     = cu_bus.inc_PC;
        c.load_ir    = cu_bus.load_IR;
        c.load_add_r = cu_bus.load_Add_R;
        c.load_reg_y = cu_bus.load_Reg_Y;
        c.load_reg_z = cu_bus.load_Reg_Z;
        c.sel1       = cu_bus.sel_bus_1_mux;
        c.sel2       = cu_bus.sel_bus_2_mux;
        c.write      = cu_bus.write;
        c.alu_sel    = cu_bus.alu_sel;
        c.halted     = cu_bus.halted;
        return c;
    endfunction

    task automatic check_eq(input string tag, input ctl_t got, input ctl_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Per-cycle control words an instruction should produce, from FET1 up to
    // (but excluding) the following FET1; illegal opcodes end after decode.
    task automatic build_seq(input logic [7:0] ir, input logic z, output bit halts);
        ctl_t c;
        int unsigned op;
        int unsigned src;
        int unsigned dst;
        op    = int'(ir[7:4]);
        src   = int'(ir[3:2]);
        dst   = int'(ir[1:0]);
        halts = 1'b0;
        exp_q.delete();

        c = '0; c.sel1 = 3'd4; c.sel2 = 2'd1; c.load_add_r = 1'b1; c.inc_pc = 1'b1;
        exp_q.push_back(c);
        c = '0; c.sel2 = 2'd2; c.load_ir = 1'b1;
        exp_q.push_back(c);

        if (op == 0) begin
            exp_q.push_back('0);
        end else if (op >= 1 && op <= 3) begin
            c = '0; c.sel1 = 3'(src); c.sel2 = 2'd1; c.load_reg_y = 1'b1;
            exp_q.push_back(c);
            c = '0; c.sel1 = 3'(dst); c.alu_sel = 4'(op); c.sel2 = 2'd0;
            c.load_r = 4'(1 << dst); c.load_reg_z = 1'b1;
            exp_q.push_back(c);
        end else if (op == 4) begin
            c = '0; c.sel1 = 3'(src); c.alu_sel = 4'd4; c.sel2 = 2'd0;
            c.load_r = 4'(1 << dst); c.load_reg_z = 1'b1;
            exp_q.push_back(c);
        end else if (op == 8 && !z) begin
            c = '0; c.inc_pc = 1'b1;
            exp_q.push_back(c);
        end else if (op >= 5 && op <= 8) begin
            c = '0; c.sel1 = 3'd4; c.sel2 = 2'd1; c.load_add_r = 1'b1;
            exp_q.push_back(c);
            c = '0; c.sel2 = 2'd2; c.load_add_r = 1'b1; c.inc_pc = (op == 5 || op == 6);
            exp_q.push_back(c);
            c = '0;
            if (op == 5) begin
                c.sel2 = 2'd2; c.load_r = 4'(1 << dst);
            end else if (op == 6) begin
                c.sel1 = 3'(src); c.write = 1'b1;
            end else begin
                c.sel2 = 2'd2; c.load_pc = 1'b1;
            end
            exp_q.push_back(c);
        end else begin
            exp_q.push_back('0);
            halts = 1'b1;
        end
    endtask

    // Entered at any time; leaves the bench at a negedge with the DUT in FET1.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1 check_eq({tag, "_rst_async"}, observe(), '0);
        @(negedge clk);
        #1 check_eq({tag, "_rst_held"}, observe(), '0);
        rst = 1'b0;
        check_eq({tag, "_idle"}, observe(), '0);
        @(negedge clk);
    endtask

    // Entered at a negedge with the DUT in FET1.
    task automatic run_instr(input logic [7:0] ir, input logic z);
        bit   halts;
        ctl_t hv;
        logic [31:0] r;
        build_seq(ir, z, halts);
        cu_bus.instruction = ir;
        foreach (exp_q[i]) begin
            if (i > 0) @(negedge clk);
            r = $urandom;
            cu_bus.zero = (i == 2) ? z : r[0];
            #1 check_eq($sformatf("ir%02h_z%0d_c%0d", ir, z, i), observe(), exp_q[i]);
        end
        @(negedge clk);
        if (halts) begin
            hv = '0; hv.halted = 1'b1;
            for (int k = 0; k < 20; k++) begin
                r = $urandom;
                cu_bus.instruction = r[7:0];
                cu_bus.zero = r[8];
                #1 check_eq($sformatf("halt_ir%02h_c%0d", ir, k), observe(), hv);
                @(negedge clk);
            end
            do_reset("halt");
        end
    endtask

    initial begin
        logic [31:0] r;
        logic [7:0]  ir;
        ctl_t        ex1;
        cu_bus.instruction = '0;
        cu_bus.zero = 1'b0;
        repeat (3) @(negedge clk);
        #1 check_eq("por_reset", observe(), '0);
        do_reset("por");

        run_instr(8'h16, 1'b0);
        run_instr(8'h43, 1'b1);
        run_instr(8'h68, 1'b0);
        run_instr(8'h80, 1'b0);
        run_instr(8'h80, 1'b1);
        run_instr(8'h55, 1'b0);
        run_instr(8'h75, 1'b0);
        run_instr(8'h25, 1'b1);
        run_instr(8'h00, 1'b1);

        // Reset mid-EX1 of ADD R1,R1
        cu_bus.instruction = 8'h15;
        cu_bus.zero = 1'b0;
        repeat (3) @(negedge clk);
        ex1 = '0; ex1.sel1 = 3'd1; ex1.alu_sel = 4'd1; ex1.load_r = 4'b0010; ex1.load_reg_z = 1'b1;
        #1 check_eq("mid_ex1", observe(), ex1);
        #2 do_reset("mid_ex1");

        for (int n = 0; n < 150; n++) begin
            r  = $urandom;
            ir = r[7:0];
            if (ir[7:4] > 4'd8 && r[12:9] != 4'd0) ir[7] = 1'b0;
            run_instr(ir, r[16]);
        end

        run_instr(8'hF0, 1'b0);
        run_instr(8'h9C, 1'b1);
        run_instr(8'h16, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
